// File: rtl/ondra_parallel_rx.sv
// ondra_parallel_rx: responder end of the Ondra parallel output port.
// It synchronises and debounces the active-low strobe, queues each byte in a
// first-word-fall-through FIFO, and answers the host with BUSY and an /ACK pulse.
// Optional build macro: ONDRA_PARRX_STATS_EN adds the rx_count_o and
// drop_count_o statistics outputs.
module ondra_parallel_rx #(
  parameter int DEPTH_LOG2     = 4,
  parameter int MIN_STB_CYCLES = 2,
  parameter int ACK_CYCLES     = 40
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [7:0]            pd_i,
  input  logic                  non_stb_i,
  output logic                  busy_o,
  output logic                  non_ack_o,
  output logic [7:0]            rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  overflow_o,
  input  logic                  clear_i
`ifdef ONDRA_PARRX_STATS_EN
  ,
  output logic [15:0]           rx_count_o,
  output logic [7:0]            drop_count_o
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int ACK_W = $clog2(ACK_CYCLES + 1);
  localparam logic [3:0]            QCNT_MIN   = 4'(MIN_STB_CYCLES);
  localparam logic [ACK_W-1:0]      ACK_LAST   = ACK_W'(ACK_CYCLES - 1);
  localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_QUAL, S_WAIT_HI, S_ACK} state_t;

  logic                  stb_meta_q, stb_s_q;
  logic [7:0]            pd_meta_q, pd_s_q;
  state_t                state_q, state_d;
  logic [3:0]            qcnt_q, qcnt_d;
  logic [ACK_W-1:0]      ack_cnt_q, ack_cnt_d;
  logic                  busy_q, busy_d;
  logic                  push_req, glitch_drop;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  fifo_full, pop, push_ok, push_drop;

  // Two-flop synchronisers; data rides alongside the strobe so it stays aligned.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      stb_meta_q <= 1'b1;
      stb_s_q    <= 1'b1;
      pd_meta_q  <= 8'hFF;
      pd_s_q     <= 8'hFF;
    end else begin
      stb_meta_q <= non_stb_i;
      stb_s_q    <= stb_meta_q;
      pd_meta_q  <= pd_i;
      pd_s_q     <= pd_meta_q;
    end
  end

  // Handshake FSM state and counter registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      qcnt_q    <= 4'd0;
      ack_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      ack_cnt_q <= ack_cnt_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic: qualify the strobe, wait for release, time the /ACK pulse.
  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    ack_cnt_d = ack_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!stb_s_q) begin
          state_d = S_QUAL;
          qcnt_d  = 4'd1;
        end
      end
      S_QUAL: begin
        if (stb_s_q) begin
          state_d = S_IDLE;
        end else if (qcnt_q == QCNT_MIN) begin
          state_d = S_WAIT_HI;
        end else begin
          qcnt_d = qcnt_q + 4'd1;
        end
      end
      S_WAIT_HI: begin
        if (stb_s_q) begin
          state_d   = S_ACK;
          ack_cnt_d = '0;
        end
      end
      S_ACK: begin
        if (ack_cnt_q == ACK_LAST) begin
          state_d = S_IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs. QUAL is tentative, so a filtered glitch never flashes BUSY;
  // BUSY covers the committed states plus a full FIFO, one cycle behind.
  always_comb begin
    push_req    = (state_q == S_QUAL) && !stb_s_q && (qcnt_q == QCNT_MIN);
    glitch_drop = (state_q == S_QUAL) && stb_s_q;
    non_ack_o   = (state_q != S_ACK);
    busy_d      = (state_q == S_WAIT_HI) || (state_q == S_ACK) || fifo_full;
  end

  // FIFO control: a push into a full FIFO survives only alongside a pop.
  always_comb begin
    fifo_full  = (level_q == LEVEL_FULL);
    pop        = rx_ready_i && (level_q != '0);
    push_ok    = push_req && (!fifo_full || pop);
    push_drop  = push_req && fifo_full && !pop;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    overflow_d = overflow_q || push_drop;
    if (clear_i) begin
      wptr_d     = '0;
      rptr_d     = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok) wptr_d = wptr_q + DEPTH_LOG2'(1);
      if (pop)     rptr_d = rptr_q + DEPTH_LOG2'(1);
      if (push_ok && !pop)      level_d = level_q + (DEPTH_LOG2 + 1)'(1);
      else if (!push_ok && pop) level_d = level_q - (DEPTH_LOG2 + 1)'(1);
    end
  end

  // FIFO pointer, occupancy and sticky overflow registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; left unreset so it can map onto RAM.
  always_ff @(posedge clk_sys) begin
    if (push_ok && !clear_i) mem_q[wptr_q] <= pd_s_q;
  end

  assign busy_o     = busy_q;
  assign rx_valid_o = (level_q != '0);
  assign rx_data_o  = rx_valid_o ? mem_q[rptr_q] : 8'h00;
  assign level_o    = level_q;
  assign overflow_o = overflow_q;

`ifdef ONDRA_PARRX_STATS_EN
  logic [15:0] rx_count_q;
  logic [7:0]  drop_count_q;

  // Accepted-byte counter wraps; drop counter (overflow + glitch) saturates.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rx_count_q   <= 16'd0;
      drop_count_q <= 8'd0;
    end else if (clear_i) begin
      rx_count_q   <= 16'd0;
      drop_count_q <= 8'd0;
    end else begin
      if (push_ok) rx_count_q <= rx_count_q + 16'd1;
      if ((push_drop || glitch_drop) && (drop_count_q != 8'hFF))
        drop_count_q <= drop_count_q + 8'd1;
    end
  end

  assign rx_count_o   = rx_count_q;
  assign drop_count_o = drop_count_q;
`endif

endmodule

// File: tb/tb_ondra_parallel_rx.sv
// Directed self-checking bench for ondra_parallel_rx (default parameters).
module tb_ondra_parallel_rx;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic [7:0] pd_i;
  logic       non_stb_i;
  logic       busy_o;
  logic       non_ack_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic [4:0] level_o;
  logic       overflow_o;
  logic       clear_i;
`ifdef ONDRA_PARRX_STATS_EN
  logic [15:0] rx_count_o;
  logic [7:0]  drop_count_o;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  ondra_parallel_rx dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .pd_i       (pd_i),
    .non_stb_i  (non_stb_i),
    .busy_o     (busy_o),
    .non_ack_o  (non_ack_o),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .level_o    (level_o),
    .overflow_o (overflow_o),
    .clear_i    (clear_i)
`ifdef ONDRA_PARRX_STATS_EN
    ,
    .rx_count_o   (rx_count_o),
    .drop_count_o (drop_count_o)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Release the strobe and measure release-to-/ACK delay and /ACK width.
  task automatic release_and_measure(output int rel_delay, output int ack_len);
    non_stb_i = 1'b1;
    rel_delay = 0;
    while (non_ack_o === 1'b1 && rel_delay < 10) begin tick(); rel_delay++; end
    ack_len = 0;
    while (non_ack_o === 1'b0 && ack_len < 100) begin tick(); ack_len++; end
  endtask

  task automatic send_byte(input logic [7:0] d, input int low_cyc, output int ack_len);
    int rel;
    pd_i = d;
    non_stb_i = 1'b0;
    repeat (low_cyc) tick();
    release_and_measure(rel, ack_len);
  endtask

  task automatic test_reset();
    reset = 1'b1; pd_i = 8'h00; non_stb_i = 1'b1; rx_ready_i = 1'b0; clear_i = 1'b0;
    repeat (3) tick();
    total_cnt++; if ({busy_o, non_ack_o, rx_valid_o, rx_data_o, level_o, overflow_o} !== {1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0})
      $display("FAIL reset_values: busy=%0b nack=%0b valid=%0b data=%02h level=%0d ovf=%0b, required 0 1 0 00 0 0", busy_o, non_ack_o, rx_valid_o, rx_data_o, level_o, overflow_o);
    else pass_cnt++;
    reset = 1'b0;
    tick();
    $display("reset: busy=%0b nack=%0b level=%0d", busy_o, non_ack_o, level_o);
  endtask

  task automatic test_single_byte();
    int rel, len;
    pd_i = 8'h9F; non_stb_i = 1'b0;
    repeat (4) tick();
    total_cnt++; if (rx_valid_o !== 1'b0) $display("FAIL early_valid: valid=%0b required 0", rx_valid_o); else pass_cnt++;
    tick();
    total_cnt++; if ({rx_valid_o, rx_data_o, level_o} !== {1'b1, 8'h9F, 5'd1})
      $display("FAIL capture: valid=%0b data=%02h level=%0d required 1 9f 1", rx_valid_o, rx_data_o, level_o);
    else pass_cnt++;
    tick();
    total_cnt++; if (busy_o !== 1'b1) $display("FAIL busy_after_qual: busy=%0b required 1", busy_o); else pass_cnt++;
    repeat (4) tick();
    release_and_measure(rel, len);
    total_cnt++; if (rel !== 3) $display("FAIL ack_delay: got %0d required 3", rel); else pass_cnt++;
    total_cnt++; if (len !== 40) $display("FAIL ack_len: got %0d required 40", len); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b1) $display("FAIL busy_at_ack_end: busy=%0b required 1", busy_o); else pass_cnt++;
    tick();
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL busy_after_ack: busy=%0b required 0", busy_o); else pass_cnt++;
    rx_ready_i = 1'b1; tick(); rx_ready_i = 1'b0;
    total_cnt++; if ({rx_valid_o, level_o} !== {1'b0, 5'd0}) $display("FAIL pop_single: valid=%0b level=%0d required 0 0", rx_valid_o, level_o); else pass_cnt++;
    $display("single_byte: data=9f ack_delay=%0d ack_len=%0d", rel, len);
  endtask

  task automatic test_glitch();
    int ack_low = 0, busy_hi = 0;
    pd_i = 8'h5A; non_stb_i = 1'b0;
    tick();
    non_stb_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (non_ack_o !== 1'b1) ack_low++;
      if (busy_o !== 1'b0) busy_hi++;
    end
    total_cnt++; if (ack_low !== 0) $display("FAIL glitch_ack: low cycles %0d required 0", ack_low); else pass_cnt++;
    total_cnt++; if (busy_hi !== 0) $display("FAIL glitch_busy: busy cycles %0d required 0", busy_hi); else pass_cnt++;
    total_cnt++; if ({rx_valid_o, level_o} !== {1'b0, 5'd0}) $display("FAIL glitch_write: valid=%0b level=%0d required 0 0", rx_valid_o, level_o); else pass_cnt++;
    $display("glitch: ack_low=%0d busy_hi=%0d level=%0d", ack_low, busy_hi, level_o);
  endtask

  task automatic test_fill_overflow();
    int len;
    for (int i = 0; i < 16; i++) send_byte(8'(i), 10, len);
    repeat (2) tick();
    total_cnt++; if ({level_o, busy_o, overflow_o} !== {5'd16, 1'b1, 1'b0})
      $display("FAIL fill: level=%0d busy=%0b ovf=%0b required 16 1 0", level_o, busy_o, overflow_o);
    else pass_cnt++;
    send_byte(8'hAA, 10, len);
    total_cnt++; if (len !== 40) $display("FAIL overflow_ack_len: got %0d required 40", len); else pass_cnt++;
    total_cnt++; if ({overflow_o, level_o} !== {1'b1, 5'd16})
      $display("FAIL overflow: ovf=%0b level=%0d required 1 16", overflow_o, level_o);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      total_cnt++; if ({rx_valid_o, rx_data_o} !== {1'b1, 8'(i)})
        $display("FAIL drain_%0d: valid=%0b data=%02h required 1 %02h", i, rx_valid_o, rx_data_o, i);
      else pass_cnt++;
      rx_ready_i = 1'b1;
      tick();
    end
    rx_ready_i = 1'b0;
    total_cnt++; if (level_o !== 5'd0) $display("FAIL drain_empty: level=%0d required 0", level_o); else pass_cnt++;
    $display("fill_overflow: ovf=%0b level=%0d", overflow_o, level_o);
  endtask

  task automatic test_clear_push();
    int rel, len;
    pd_i = 8'h77; non_stb_i = 1'b0;
    repeat (4) tick();
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    total_cnt++; if ({rx_valid_o, level_o, overflow_o} !== {1'b0, 5'd0, 1'b0})
      $display("FAIL clear_push: valid=%0b level=%0d ovf=%0b required 0 0 0", rx_valid_o, level_o, overflow_o);
    else pass_cnt++;
`ifdef ONDRA_PARRX_STATS_EN
    total_cnt++; if (rx_count_o !== 16'd0) $display("FAIL clear_rx_count: got %0d required 0", rx_count_o); else pass_cnt++;
`endif
    repeat (5) tick();
    release_and_measure(rel, len);
    total_cnt++; if (len !== 40) $display("FAIL clear_ack_len: got %0d required 40", len); else pass_cnt++;
    $display("clear_push: level=%0d ovf=%0b ack_len=%0d", level_o, overflow_o, len);
  endtask

  task automatic test_full_concurrent_pop();
    int rel, len;
    logic [7:0] exp_q [$];
    for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), 10, len);
    for (int i = 1; i < 16; i++) exp_q.push_back(8'(8'h20 + i));
    exp_q.push_back(8'h55);
    pd_i = 8'h55; non_stb_i = 1'b0;
    repeat (4) tick();
    rx_ready_i = 1'b1; tick(); rx_ready_i = 1'b0;
    total_cnt++; if ({level_o, overflow_o, rx_data_o} !== {5'd16, 1'b0, 8'h21})
      $display("FAIL concurrent_pop: level=%0d ovf=%0b head=%02h required 16 0 21", level_o, overflow_o, rx_data_o);
    else pass_cnt++;
    repeat (5) tick();
    release_and_measure(rel, len);
    for (int i = 0; i < 16; i++) begin
      total_cnt++; if ({rx_valid_o, rx_data_o} !== {1'b1, exp_q[i]})
        $display("FAIL cpop_drain_%0d: valid=%0b data=%02h required 1 %02h", i, rx_valid_o, rx_data_o, exp_q[i]);
      else pass_cnt++;
      rx_ready_i = 1'b1;
      tick();
    end
    rx_ready_i = 1'b0;
    $display("full_concurrent_pop: level=%0d ovf=%0b", level_o, overflow_o);
  endtask

  task automatic test_reset_mid_ack();
    pd_i = 8'hC3; non_stb_i = 1'b0;
    repeat (10) tick();
    non_stb_i = 1'b1;
    repeat (23) tick();
    total_cnt++; if ({non_ack_o, busy_o, level_o} !== {1'b0, 1'b1, 5'd1})
      $display("FAIL pre_reset_ack: nack=%0b busy=%0b level=%0d required 0 1 1", non_ack_o, busy_o, level_o);
    else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++; if ({non_ack_o, busy_o, level_o, rx_valid_o} !== {1'b1, 1'b0, 5'd0, 1'b0})
      $display("FAIL reset_mid_ack: nack=%0b busy=%0b level=%0d valid=%0b required 1 0 0 0", non_ack_o, busy_o, level_o, rx_valid_o);
    else pass_cnt++;
    tick();
    reset = 1'b0;
    tick();
    $display("reset_mid_ack: nack=%0b busy=%0b level=%0d", non_ack_o, busy_o, level_o);
  endtask

  task automatic test_reset_requalify();
    int n = 0, rel, len;
    pd_i = 8'h3C; non_stb_i = 1'b0;
    repeat (3) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    while (rx_valid_o !== 1'b1 && n < 12) begin tick(); n++; end
    total_cnt++; if ({rx_valid_o, rx_data_o} !== {1'b1, 8'h3C})
      $display("FAIL requalify: valid=%0b data=%02h required 1 3c", rx_valid_o, rx_data_o);
    else pass_cnt++;
    repeat (3) tick();
    release_and_measure(rel, len);
    total_cnt++; if (len !== 40) $display("FAIL requalify_ack_len: got %0d required 40", len); else pass_cnt++;
    rx_ready_i = 1'b1; tick(); rx_ready_i = 1'b0;
    $display("reset_requalify: wait=%0d ack_len=%0d", n, len);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_fill_overflow();
    test_clear_push();
    test_full_concurrent_pop();
    test_reset_mid_ack();
    test_reset_requalify();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
